temporal_lte_array: RTL and testbench
=====================================

TEMPORAL_LTE_ARRAY -- requirements
Module: temporal_lte_array

Interface
REQ-001 Parameter NUM_CH, default 8: number of independent a/b comparison channels (1..64).
REQ-002 Parameter GAMMA_CYCLE_WIDTH, default 16: aclk cycles per gamma cycle (>=4).
REQ-003 Parameter PULSE_WIDTH, default 8: output pulse length in aclk cycles (1..GAMMA_CYCLE_WIDTH-2).
REQ-004 aclk  input  1  single clock; all state updates on posedge aclk.
REQ-005 grst  input  1  reset, synchronous, active-high.
REQ-006 gamma_sync  input  1  forces the gamma counter to restart; all channels clear.
REQ-007 mode  input  1  0 = PULSE output, 1 = LEVEL output (held to gamma end); sampled only at gamma start.
REQ-008 a  input  NUM_CH  per-channel spike input a[i].
REQ-009 b  input  NUM_CH  per-channel spike input b[i].
REQ-010 q  output  NUM_CH  per-channel result spike, asserted iff a[i] arrived no later than b[i].
REQ-011 gamma_start  output  1  one-cycle pulse marking cycle 0 of each gamma cycle.

Function
REQ-012 Gamma counter gcnt (width $clog2(GAMMA_CYCLE_WIDTH)) shall count 0..GAMMA_CYCLE_WIDTH-1, then wrap to 0.
REQ-013 gamma_sync=1 shall load gcnt=0 on the next edge; gamma_sync has priority over wrap.
REQ-014 gamma_start shall be 1 exactly in cycles where gcnt==0.
REQ-015 Arrival of x[i] shall be its first rising edge (x[i]=1, registered x_prev[i]=0) within the current gamma cycle; later edges are ignored.
REQ-016 x_prev shall be cleared at gamma boundary, so an input held high across the boundary counts as an arrival in cycle 0.
REQ-017 Each channel FSM: IDLE, FIRE, BLOCKED, DONE.
REQ-018 IDLE: a-arrival (with or without simultaneous b-arrival) -> FIRE; b-arrival alone -> BLOCKED; otherwise stay.
REQ-019 Simultaneous a and b arrival in the same cycle shall resolve as a wins (less-than-or-equal).
REQ-020 FIRE: q[i]=1; in PULSE mode, after exactly PULSE_WIDTH cycles -> DONE; in LEVEL mode, remain until gamma end.
REQ-021 BLOCKED and DONE: q[i]=0; ignore all further arrivals until gamma end.
REQ-022 q[i] shall be registered: first q[i]=1 cycle is the cycle after a's arrival (latency 1).
REQ-023 At gamma end (gcnt wrap or gamma_sync), every channel shall return to IDLE and q shall be 0 in the following cycle, truncating any pulse in progress.
REQ-024 Arrivals sampled in the same cycle as a gamma end shall be discarded (boundary clear has priority).
REQ-025 Pulse counter per channel: width $clog2(PULSE_WIDTH+1), saturating; never wraps.
REQ-026 mode shall be latched into an internal register at gcnt==0 and held for the whole gamma cycle; mid-cycle changes have no effect.
REQ-027 Channels shall be fully independent; no cross-channel interaction.

Reset
REQ-028 On grst=1 at posedge aclk: gcnt=0, all FSMs=IDLE, pulse counters=0, x_prev=0, latched mode=0.
REQ-029 Outputs during/after reset: q=0; gamma_start=1 in the first cycle after grst deasserts (gcnt==0).
REQ-030 grst asserted mid-pulse shall terminate the pulse on the next edge; grst has priority over gamma_sync.

Structure
REQ-031 Package temporal_pkg: ch_state_t enum (IDLE, FIRE, BLOCKED, DONE), out_mode_t enum (PULSE, LEVEL).
REQ-032 Sub-module lte_channel: one channel FSM, edge detector and pulse counter; instantiated NUM_CH times via generate.
REQ-033 Gamma counter, mode latch and gamma_start logic reside in temporal_lte_array top.

Verification
REQ-034 Defaults, mode=0; a[0] rises at gcnt=3, b[0] at gcnt=6 -> q[0]=1 for gcnt=4..11, then 0.
REQ-035 b[1] rises at gcnt=2, a[1] at gcnt=5 -> q[1]=0 for the whole gamma cycle.
REQ-036 a[2], b[2] both rise at gcnt=7 -> q[2]=1 for gcnt=8..15; a[3] rises at gcnt=12 -> q[3]=1 for gcnt=13..15, 0 at next gcnt=0 (truncation).
REQ-037 mode=1 latched at gcnt=0; a[4] rises at gcnt=1 -> q[4]=1 for gcnt=2..15; mode toggled to 0 at gcnt=5 -> no effect.
REQ-038 a[5] pulses twice (gcnt=2, gcnt=10), no b -> single 8-cycle pulse only; a[5] held high across boundary -> new pulse starts at gcnt=1 of next gamma.
REQ-039 grst at gcnt=6 during active pulse -> q=0 next cycle, gamma_start=1 next cycle; gamma_sync at gcnt=9 -> gcnt=0 and all q cleared next cycle.

Source files
------------

// File: rtl/temporal_pkg.sv
// temporal_pkg: shared channel state and output mode types for the temporal LTE array
package temporal_pkg;
  typedef enum logic [1:0] {IDLE, FIRE, BLOCKED, DONE} ch_state_t;
  typedef enum logic {PULSE, LEVEL} out_mode_t;
endpackage

// File: rtl/lte_channel.sv
// lte_channel: one a<=b race channel with first-edge detection and a saturating pulse counter
module lte_channel
  import temporal_pkg::*;
#(
  parameter int PULSE_WIDTH = 8
) (
  input  logic aclk,
  input  logic grst,
  input  logic clr,
  input  logic level,
  input  logic a,
  input  logic b,
  output logic q
);
  localparam int PCW = $clog2(PULSE_WIDTH + 1);
  localparam logic [PCW-1:0] PMAX = PCW'(PULSE_WIDTH);
  ch_state_t state_q, state_d;
  logic [PCW-1:0] pcnt_q, pcnt_d;
  logic a_prev_q, a_prev_d, b_prev_q, b_prev_d;
  logic arr_a, arr_b;
  always_comb begin
    arr_a = a & ~a_prev_q;
    arr_b = b & ~b_prev_q;
    a_prev_d = clr ? 1'b0 : a;
    b_prev_d = clr ? 1'b0 : b;
    state_d = state_q;
    pcnt_d = pcnt_q;
    case (state_q)
      IDLE: state_d = arr_a ? FIRE : arr_b ? BLOCKED : IDLE;
      FIRE: begin
        pcnt_d = (pcnt_q == PMAX) ? pcnt_q : pcnt_q + 1'b1;
        state_d = (!level && pcnt_q == PMAX - 1'b1) ? DONE : FIRE;
      end
      default: state_d = state_q;
    endcase
    // boundary clear wins over any arrival sampled in the same cycle
    if (clr) begin
      state_d = IDLE;
      pcnt_d = '0;
    end
  end
  always_ff @(posedge aclk) begin
    if (grst) begin
      state_q <= IDLE;
      pcnt_q <= '0;
      a_prev_q <= 1'b0;
      b_prev_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pcnt_q <= pcnt_d;
      a_prev_q <= a_prev_d;
      b_prev_q <= b_prev_d;
    end
  end
  assign q = state_q == FIRE;
endmodule

// File: rtl/temporal_lte_array.sv
// temporal_lte_array: gamma-cycle timebase and mode latch driving NUM_CH independent LTE channels
module temporal_lte_array
  import temporal_pkg::*;
#(
  parameter int NUM_CH = 8,
  parameter int GAMMA_CYCLE_WIDTH = 16,
  parameter int PULSE_WIDTH = 8
) (
  input  logic              aclk,
  input  logic              grst,
  input  logic              gamma_sync,
  input  logic              mode,
  input  logic [NUM_CH-1:0] a,
  input  logic [NUM_CH-1:0] b,
  output logic [NUM_CH-1:0] q,
  output logic              gamma_start
);
  localparam int GW = $clog2(GAMMA_CYCLE_WIDTH);
  localparam logic [GW-1:0] GLAST = GW'(GAMMA_CYCLE_WIDTH - 1);
  logic [GW-1:0] gcnt_q, gcnt_d;
  out_mode_t mode_q, mode_d;
  logic gend;
  always_comb begin
    gend = gamma_sync | (gcnt_q == GLAST);
    gcnt_d = gend ? '0 : gcnt_q + 1'b1;
    mode_d = (gcnt_q == '0) ? out_mode_t'(mode) : mode_q;
    gamma_start = gcnt_q == '0;
  end
  always_ff @(posedge aclk) begin
    if (grst) begin
      gcnt_q <= '0;
      mode_q <= PULSE;
    end else begin
      gcnt_q <= gcnt_d;
      mode_q <= mode_d;
    end
  end
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    lte_channel #(.PULSE_WIDTH(PULSE_WIDTH)) u_ch (
      .aclk (aclk),
      .grst (grst),
      .clr  (gend),
      .level(mode_q == LEVEL),
      .a    (a[i]),
      .b    (b[i]),
      .q    (q[i])
    );
  end
endmodule

// File: tb/tb_temporal_lte_array.sv
// tb_temporal_lte_array: directed table and sequence checks of the temporal LTE array
module tb_temporal_lte_array;
  logic aclk = 1'b0;
  logic grst = 1'b1;
  logic gamma_sync = 1'b0;
  logic mode = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic [7:0] q;
  logic gamma_start;
  int n_cmp = 0;
  int n_bad = 0;
  typedef struct {int ch; int ar; int br; int qf; int ql;} vec_t;
  vec_t tbl[8];
  always #5 aclk = ~aclk;
  temporal_lte_array dut (
    .aclk       (aclk),
    .grst       (grst),
    .gamma_sync (gamma_sync),
    .mode       (mode),
    .a          (a),
    .b          (b),
    .q          (q),
    .gamma_start(gamma_start)
  );
  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h want %02h", nm, act, exp);
    end
  endtask
  task automatic cyc(input logic [7:0] av, input logic [7:0] bv, input logic mv, input logic sv,
                     input logic rv, input logic [7:0] eq, input logic egs, input string tag);
    chk({tag, " q"}, q, eq);
    chk({tag, " gamma_start"}, {7'b0, gamma_start}, {7'b0, egs});
    a = av;
    b = bv;
    mode = mv;
    gamma_sync = sv;
    grst = rv;
    @(posedge aclk);
    #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [7:0] av, bv, eq;
    tbl[0] = '{0, 3, 6, 4, 11};
    tbl[1] = '{1, 5, 2, 99, -1};
    tbl[2] = '{2, 7, 7, 8, 15};
    tbl[3] = '{3, 12, -1, 13, 15};
    tbl[4] = '{4, 15, -1, 99, -1};
    tbl[5] = '{5, 14, -1, 15, 15};
    tbl[6] = '{6, 0, -1, 1, 8};
    tbl[7] = '{7, -1, 0, 99, -1};
    repeat (3) @(posedge aclk);
    #1;
    chk("reset q", q, 8'h00);
    chk("reset gamma_start", {7'b0, gamma_start}, 8'h01);
    for (int k = 0; k < 16; k++) begin
      av = '0;
      bv = '0;
      eq = '0;
      for (int j = 0; j < 8; j++) begin
        av[tbl[j].ch] = tbl[j].ar == k;
        bv[tbl[j].ch] = tbl[j].br == k;
        eq[tbl[j].ch] = k >= tbl[j].qf && k <= tbl[j].ql;
      end
      cyc(av, bv, 1'b0, 1'b0, 1'b0, eq, k == 0, $sformatf("g1 k%0d", k));
    end
    for (int k = 0; k < 16; k++)
      cyc(k == 1 ? 8'h10 : 8'h00, 8'h00, k < 5, 1'b0, 1'b0, k >= 2 ? 8'h10 : 8'h00, k == 0,
          $sformatf("level k%0d", k));
    for (int k = 0; k < 16; k++)
      cyc((k == 2 || k == 10 || k == 15) ? 8'h20 : 8'h00, 8'h00, 1'b0, 1'b0, 1'b0,
          (k >= 3 && k <= 10) ? 8'h20 : 8'h00, k == 0, $sformatf("double k%0d", k));
    for (int k = 0; k < 16; k++)
      cyc(k <= 1 ? 8'h20 : 8'h00, 8'h00, 1'b0, 1'b0, 1'b0,
          (k >= 1 && k <= 8) ? 8'h20 : 8'h00, k == 0, $sformatf("held k%0d", k));
    for (int k = 0; k < 7; k++)
      cyc(k == 2 ? 8'h01 : 8'h00, 8'h00, 1'b0, 1'b0, k == 6, k >= 3 ? 8'h01 : 8'h00, k == 0,
          $sformatf("grst k%0d", k));
    for (int k = 0; k < 10; k++)
      cyc(k == 1 ? 8'h02 : 8'h00, 8'h00, 1'b0, k == 9, 1'b0, k >= 2 ? 8'h02 : 8'h00, k == 0,
          $sformatf("after_rst k%0d", k));
    for (int k = 0; k < 4; k++)
      cyc(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, k == 0, $sformatf("after_sync k%0d", k));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
